data_mem_bridge: RTL and testbench

DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

---
 rtl/data_mem_bridge.sv | 139 +++++++++++++
 tb/tb_data_mem_bridge.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bridge.sv
// Data-side memory bridge for a single-cycle CPU. It decodes a word RAM and a
// three-register countdown timer (CTRL / PRESET / COUNT). Loads are combinational,
// and stores commit at the rising clock edge.
module data_mem_bridge #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
    input  logic        clk_I,
    input  logic        reset_I,
    input  logic [31:0] addr_I,
    input  logic [31:0] writeData_I,
    input  logic        memWrite_I,
    output logic [31:0] readData_O,
    output logic        irq_O
);

    localparam int IDX_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    // Address decode. The byte-offset bits are dropped, so every access is word-aligned.
    logic [29:0]      word_a;
    logic             ram_hit, ctrl_hit, preset_hit, count_hit;
    logic [IDX_W-1:0] ram_idx;

    assign word_a     = addr_I[31:2];
    assign ram_hit    = 32'({2'b00, word_a}) < RAM_WORDS;
    assign ram_idx    = word_a[IDX_W-1:0];
    assign ctrl_hit   = word_a == TIMER_BASE[31:2];
    assign preset_hit = word_a == TIMER_BASE[31:2] + 30'd1;
    assign count_hit  = word_a == TIMER_BASE[31:2] + 30'd2;

    logic [31:0] mem_q [RAM_WORDS];

    state_t      state_q, state_d;
    logic        en_q, en_d, mode_q, mode_d, im_q, im_d;
    logic        pend_q, pend_d, irq_q, irq_d;
    logic [31:0] preset_q, preset_d, count_q, count_d;
    logic        mem_we, ctrl_wr, preset_wr;

    assign mem_we    = memWrite_I & ram_hit;
    assign ctrl_wr   = memWrite_I & ctrl_hit;
    assign preset_wr = memWrite_I & preset_hit;

    // Combinational load mux. Reading mem_q directly returns the old word during a same-cycle write.
    always_comb begin
        readData_O = 32'd0;
        if (ram_hit)         readData_O = mem_q[ram_idx];
        else if (ctrl_hit)   readData_O = {28'd0, im_q, 1'b0, mode_q, en_q};
        else if (preset_hit) readData_O = preset_q;
        else if (count_hit)  readData_O = count_q;
    end

    // Timer FSM next state. A CPU store to CTRL is applied last, so it wins over the FSM's EN clear and pend set.
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        pend_d   = pend_q;
        preset_d = preset_q;
        count_d  = count_q;
        case (state_q)
            IDLE: if (en_q) state_d = LOAD;
            LOAD: begin
                if (preset_q == 32'd0) begin
                    count_d = 32'd0;
                    state_d = INT;
                end else begin
                    count_d = preset_q;
                    state_d = CNT;
                end
            end
            CNT: begin
                if (!en_q) begin
                    state_d = IDLE;
                end else if (count_q <= 32'd1) begin
                    count_d = 32'd0;
                    state_d = INT;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            INT: begin
                pend_d = 1'b1;
                if (mode_q) begin
                    state_d = LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (preset_wr) preset_d = writeData_I;
        if (ctrl_wr) begin
            en_d   = writeData_I[0];
            mode_d = writeData_I[1];
            im_d   = writeData_I[3];
            pend_d = 1'b0;
        end
        irq_d = pend_d & im_d;
    end

    assign irq_O = irq_q;

    // Timer state registers. A synchronous reset abandons any count in progress.
    always_ff @(posedge clk_I) begin
        if (reset_I) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            mode_q   <= 1'b0;
            im_q     <= 1'b0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
            preset_q <= preset_d;
            count_q  <= count_d;
        end
    end

    // Word RAM. Reset clears every word, so it is built from flops rather than a RAM macro.
    always_ff @(posedge clk_I) begin
        if (reset_I) begin
            for (int i = 0; i < int'(RAM_WORDS); i++) mem_q[i] <= 32'd0;
        end else if (mem_we) begin
            mem_q[ram_idx] <= writeData_I;
        end
    end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge: RAM access, decode holes, and timer sequencing.
module tb_data_mem_bridge;

    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;

    logic        clk = 1'b0;
    logic        reset_I = 1'b0;
    logic [31:0] addr_I = 32'd0;
    logic [31:0] writeData_I = 32'd0;
    logic        memWrite_I = 1'b0;
    logic [31:0] readData_O;
    logic        irq_O;

    int nvec = 0;
    int nerr = 0;

    data_mem_bridge dut (
        .clk_I      (clk),
        .reset_I    (reset_I),
        .addr_I     (addr_I),
        .writeData_I(writeData_I),
        .memWrite_I (memWrite_I),
        .readData_O (readData_O),
        .irq_O      (irq_O)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr_I      = a;
        writeData_I = d;
        memWrite_I  = 1'b1;
        tick();
        memWrite_I  = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        addr_I = a;
        #1;
        d = readData_O;
    endtask

    logic [31:0] rd;

    initial begin
        // Reset
        reset_I = 1'b1;
        tick(); tick();
        reset_I = 1'b0;
        load(32'h10, rd);   chk("rst_ram", rd, 32'h0);
        load(A_CTRL, rd);   chk("rst_ctrl", rd, 32'h0);
        load(A_COUNT, rd);  chk("rst_count", rd, 32'h0);
        chk("rst_irq", {31'd0, irq_O}, 32'h0);

        // RAM store/load, ignored byte offset, unmapped region
        store(32'h10, 32'hDEADBEEF);
        load(32'h12, rd);     chk("ram_unaligned", rd, 32'hDEADBEEF);
        load(32'h2000, rd);   chk("unmapped_rd", rd, 32'h0);
        store(32'h2000, 32'h1111_2222);
        load(32'h2000, rd);   chk("unmapped_st", rd, 32'h0);
        load(32'h7F0C, rd);   chk("unmapped_tmr", rd, 32'h0);
        load(32'hFFC, rd);    chk("ram_top", rd, 32'h0);
        // Read during write returns the old word
        addr_I = 32'h10; writeData_I = 32'h1234_5678; memWrite_I = 1'b1;
        #1; chk("rdw_old", readData_O, 32'hDEADBEEF);
        tick(); memWrite_I = 1'b0;
        load(32'h10, rd);     chk("rdw_new", rd, 32'h1234_5678);
        // CTRL keeps only bits 0, 1, and 3; COUNT is read-only
        store(A_CTRL, 32'hFFFF_FFF6);
        load(A_CTRL, rd);     chk("ctrl_mask", rd, 32'h2);
        store(A_CTRL, 32'h0);
        store(A_COUNT, 32'h55);
        load(A_COUNT, rd);    chk("count_ro", rd, 32'h0);

        // One-shot: PRESET=3, CTRL=0x9
        store(A_PRESET, 32'd3);
        store(A_CTRL, 32'h9);           // IDLE with EN set
        addr_I = A_COUNT;
        tick();                          // LOAD
        tick(); chk("os_c3", readData_O, 32'd3);
        tick(); chk("os_c2", readData_O, 32'd2);
        tick(); chk("os_c1", readData_O, 32'd1);
        tick(); chk("os_c0", readData_O, 32'd0);
        chk("os_irq_int", {31'd0, irq_O}, 32'h0);
        tick(); chk("os_irq", {31'd0, irq_O}, 32'h1);
        load(A_CTRL, rd);     chk("os_en_clr", rd, 32'h8);
        tick(); tick(); chk("os_irq_hold", {31'd0, irq_O}, 32'h1);
        load(A_COUNT, rd);    chk("os_cnt_hold", rd, 32'h0);
        store(A_CTRL, 32'h8);
        chk("os_irq_clr", {31'd0, irq_O}, 32'h0);

        // Auto-reload: PRESET=2, CTRL=0xB
        store(A_PRESET, 32'd2);
        store(A_CTRL, 32'hB);
        addr_I = A_COUNT;
        tick();                          // LOAD
        tick(); chk("ar_c2a", readData_O, 32'd2);
        tick(); chk("ar_c1a", readData_O, 32'd1);
        tick(); chk("ar_c0a", readData_O, 32'd0);   // INT
        tick(); chk("ar_irq", {31'd0, irq_O}, 32'h1); // LOAD
        chk("ar_load", readData_O, 32'd0);
        tick(); chk("ar_c2b", readData_O, 32'd2);
        tick(); chk("ar_c1b", readData_O, 32'd1);
        tick(); chk("ar_c0b", readData_O, 32'd0);   // INT again
        // CTRL=0 stored while in INT: the store wins over the pend set
        store(A_CTRL, 32'h0);
        chk("int_st_irq", {31'd0, irq_O}, 32'h0);
        load(A_CTRL, rd);     chk("int_st_ctrl", rd, 32'h0);
        tick(); chk("int_st_irq2", {31'd0, irq_O}, 32'h0);
        tick(); chk("int_st_irq3", {31'd0, irq_O}, 32'h0);

        // PRESET=0: LOAD goes straight to INT
        store(A_PRESET, 32'd0);
        store(A_CTRL, 32'h9);
        addr_I = A_COUNT;
        tick();                          // LOAD
        tick(); chk("p0_cnt", readData_O, 32'd0);   // INT
        chk("p0_irq_int", {31'd0, irq_O}, 32'h0);
        tick(); chk("p0_irq", {31'd0, irq_O}, 32'h1);
        store(A_CTRL, 32'h0);

        // EN=0 during CNT, and a PRESET store during CNT
        store(A_PRESET, 32'd10);
        store(A_CTRL, 32'h1);
        addr_I = A_COUNT;
        tick();                          // LOAD
        tick(); chk("en_c10", readData_O, 32'd10);
        tick();                          // 9
        store(A_PRESET, 32'd3);
        load(A_COUNT, rd);    chk("pr_run", rd, 32'd8);
        tick();                          // 7
        store(A_CTRL, 32'h0);
        load(A_COUNT, rd);    chk("en0_c6", rd, 32'd6);
        tick(); chk("en0_hold", readData_O, 32'd6);
        tick(); chk("en0_idle", readData_O, 32'd6);
        store(A_CTRL, 32'h9);
        addr_I = A_COUNT;
        tick();                          // LOAD
        tick(); chk("pr_new", readData_O, 32'd3);
        store(A_CTRL, 32'h0);
        tick();                          // IDLE

        // Reset mid-CNT with COUNT=5, plus a store in the same cycle
        store(A_PRESET, 32'd5);
        store(A_CTRL, 32'h9);
        addr_I = A_COUNT;
        tick();                          // LOAD
        tick(); chk("rs_c5", readData_O, 32'd5);
        reset_I = 1'b1;
        addr_I = 32'h10; writeData_I = 32'hAAAA_5555; memWrite_I = 1'b1;
        tick();
        reset_I = 1'b0; memWrite_I = 1'b0;
        load(A_COUNT, rd);    chk("rs_count", rd, 32'd0);
        chk("rs_irq", {31'd0, irq_O}, 32'h0);
        load(32'h10, rd);     chk("rs_ram", rd, 32'h0);
        load(A_CTRL, rd);     chk("rs_ctrl", rd, 32'h0);
        addr_I = A_COUNT;
        tick(); tick(); tick(); tick(); tick(); tick();
        chk("rs_idle_cnt", readData_O, 32'd0);
        chk("rs_idle_irq", {31'd0, irq_O}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
